// File: rtl/riscv_mc_control_pkg.sv
// Shared encodings for the RV32I multicycle control unit: opcodes, FSM states,
// datapath select codes and the state-to-control decode.
package riscv_mc_control_pkg;

    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;

    localparam logic [6:0] FUNCT7_MULDIV = 7'b0000001;

    typedef enum logic [3:0] {
        ST_FETCH    = 4'd0,
        ST_DECODE   = 4'd1,
        ST_EXEC_R   = 4'd2,
        ST_EXEC_I   = 4'd3,
        ST_ALU_WB   = 4'd4,
        ST_MEM_ADDR = 4'd5,
        ST_MEM_RD   = 4'd6,
        ST_MEM_WB   = 4'd7,
        ST_MEM_WR   = 4'd8,
        ST_BRANCH   = 4'd9,
        ST_JAL      = 4'd10,
        ST_JALR     = 4'd11,
        ST_LUI      = 4'd12,
        ST_AUIPC    = 4'd13,
        ST_TRAP     = 4'd14,
        ST_MULDIV   = 4'd15
    } state_t;

    localparam logic [1:0] A_PC    = 2'b00, A_RS1 = 2'b01, A_PCOLD = 2'b10, A_ZERO = 2'b11;
    localparam logic [1:0] B_RS2   = 2'b00, B_FOUR = 2'b01, B_IMM = 2'b10;
    localparam logic [1:0] ALU_ADD = 2'b00, ALU_BR = 2'b01, ALU_R = 2'b10, ALU_I = 2'b11;
    localparam logic [1:0] PC_ALU  = 2'b00, PC_ALUOUT = 2'b01, PC_JALR = 2'b10;
    localparam logic [1:0] WB_ALU  = 2'b00, WB_MDR = 2'b01, WB_PC4 = 2'b10, WB_MUL = 2'b11;

    typedef struct packed {
        logic       pc_wr;
        logic       pc_cond;
        logic       iord;
        logic       mem_rd;
        logic       mem_wr;
        logic       ir_wr;
        logic       reg_wr;
        logic [1:0] wb_sel;
        logic [1:0] alu_a;
        logic [1:0] alu_b;
        logic [1:0] alu_op;
        logic [1:0] pc_sel;
    } ctrl_t;

    // Moore decode: only the state, the wait-counter "last" flag and the
    // latched M-unit flag shape the controls.
    function automatic ctrl_t ctrl_decode(input state_t st, input logic last, input logic md);
        ctrl_t c;
        c = '0;
        case (st)
            ST_FETCH:    begin c.mem_rd = 1'b1; c.alu_b = B_FOUR; c.ir_wr = last; c.pc_wr = last; end
            ST_DECODE:   begin c.alu_a = A_PCOLD; c.alu_b = B_IMM; end
            ST_EXEC_R:   begin c.alu_a = A_RS1; c.alu_b = B_RS2; c.alu_op = ALU_R; end
            ST_EXEC_I:   begin c.alu_a = A_RS1; c.alu_b = B_IMM; c.alu_op = ALU_I; end
            ST_ALU_WB:   begin c.reg_wr = 1'b1; c.wb_sel = md ? WB_MUL : WB_ALU; end
            ST_MEM_ADDR: begin c.alu_a = A_RS1; c.alu_b = B_IMM; end
            ST_MEM_RD:   begin c.iord = 1'b1; c.mem_rd = 1'b1; end
            ST_MEM_WB:   begin c.reg_wr = 1'b1; c.wb_sel = WB_MDR; end
            ST_MEM_WR:   begin c.iord = 1'b1; c.mem_wr = 1'b1; end
            ST_BRANCH:   begin c.alu_a = A_RS1; c.alu_b = B_RS2; c.alu_op = ALU_BR;
                               c.pc_cond = 1'b1; c.pc_sel = PC_ALUOUT; end
            ST_JAL:      begin c.reg_wr = 1'b1; c.wb_sel = WB_PC4; c.pc_wr = 1'b1; c.pc_sel = PC_ALUOUT; end
            ST_JALR:     begin c.alu_a = A_RS1; c.alu_b = B_IMM; c.reg_wr = 1'b1;
                               c.wb_sel = WB_PC4; c.pc_wr = 1'b1; c.pc_sel = PC_JALR; end
            ST_LUI:      begin c.alu_a = A_ZERO; c.alu_b = B_IMM; end
            ST_AUIPC:    begin c.alu_a = A_PCOLD; c.alu_b = B_IMM; end
            ST_MULDIV:   begin c.alu_a = A_RS1; c.alu_b = B_RS2; end
            default:     c = '0;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/riscv_mc_control_wait_counter.sv
// Memory-wait counter: counts 0..MEM_WAIT while enabled, flags the last cycle,
// and wraps to 0 on that cycle so the next memory state starts fresh.
module mc_wait_counter #(
    parameter int MEM_WAIT = 0
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_en,
    input  logic i_clr,
    output logic o_last
);

    logic [3:0] r_cnt;

    assign o_last = (r_cnt == 4'(MEM_WAIT));

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n)
            r_cnt <= '0;
        else if (i_clr || o_last)
            r_cnt <= '0;
        else if (i_en)
            r_cnt <= r_cnt + 4'd1;
    end

endmodule

// File: rtl/riscv_mc_control.sv
// Multicycle RV32I control FSM. Optional M-extension sequencing is enabled
// with the MULDIV_EN macro.
module riscv_mc_control
    import riscv_mc_control_pkg::*;
#(
    parameter int MEM_WAIT = 0,
    parameter int STATE_W  = 4
) (
    input  logic               iCLK,
    input  logic               iRSTn,
    input  logic [6:0]         iOpcode,
    input  logic [6:0]         iFunct7,
    input  logic               iMulDivDone,
    output logic               oEscrevePC,
    output logic               oEscrevePCCond,
    output logic               oIouD,
    output logic               oLeMem,
    output logic               oEscreveMem,
    output logic               oEscreveIR,
    output logic               oEscreveReg,
    output logic [1:0]         oMemparaReg,
    output logic [1:0]         oOrigAULA,
    output logic [1:0]         oOrigBULA,
    output logic [1:0]         oOpALU,
    output logic [1:0]         oOrigPC,
    output logic               oIllegal,
    output logic [STATE_W-1:0] oState
);

    state_t r_state;
    logic   r_illegal;
    logic   r_md;
    logic   w_mem;
    logic   w_last;
    logic   w_is_md;
    ctrl_t  w_ctrl;

`ifdef MULDIV_EN
    assign w_is_md = (iFunct7 == FUNCT7_MULDIV);
`else
    logic w_unused;
    assign w_unused = ^{iFunct7, iMulDivDone};
    assign w_is_md  = 1'b0;
`endif

    assign w_mem = (r_state == ST_FETCH) || (r_state == ST_MEM_RD) || (r_state == ST_MEM_WR);

    mc_wait_counter #(.MEM_WAIT(MEM_WAIT)) u_wait (
        .i_clk   (iCLK),
        .i_rst_n (iRSTn),
        .i_en    (w_mem),
        .i_clr   (!w_mem),
        .o_last  (w_last)
    );

    always_ff @(posedge iCLK or negedge iRSTn) begin
        if (!iRSTn) begin
            r_state   <= ST_FETCH;
            r_illegal <= 1'b0;
            r_md      <= 1'b0;
        end else begin
            case (r_state)
                ST_FETCH: begin
                    r_md <= 1'b0;
                    if (w_last) r_state <= ST_DECODE;
                end
                ST_DECODE: begin
                    case (iOpcode)
                        OPC_OP: begin
                            r_state <= w_is_md ? ST_MULDIV : ST_EXEC_R;
                            r_md    <= w_is_md;
                        end
                        OPC_OP_IMM:          r_state <= ST_EXEC_I;
                        OPC_LOAD, OPC_STORE: r_state <= ST_MEM_ADDR;
                        OPC_BRANCH:          r_state <= ST_BRANCH;
                        OPC_JAL:             r_state <= ST_JAL;
                        OPC_JALR:            r_state <= ST_JALR;
                        OPC_LUI:             r_state <= ST_LUI;
                        OPC_AUIPC:           r_state <= ST_AUIPC;
                        default: begin
                            r_state   <= ST_TRAP;
                            r_illegal <= 1'b1;
                        end
                    endcase
                end
                ST_EXEC_R, ST_EXEC_I, ST_LUI, ST_AUIPC: r_state <= ST_ALU_WB;
                ST_ALU_WB, ST_MEM_WB, ST_BRANCH, ST_JAL, ST_JALR: r_state <= ST_FETCH;
                ST_MEM_ADDR: r_state <= (iOpcode == OPC_STORE) ? ST_MEM_WR : ST_MEM_RD;
                ST_MEM_RD:   if (w_last) r_state <= ST_MEM_WB;
                ST_MEM_WR:   if (w_last) r_state <= ST_FETCH;
                ST_TRAP:     r_state <= ST_TRAP;
`ifdef MULDIV_EN
                ST_MULDIV:   if (iMulDivDone) r_state <= ST_ALU_WB;
`endif
                default:     r_state <= ST_FETCH;
            endcase
        end
    end

    // Reset forces every control low so an aborted instruction leaves no write behind.
    always_comb begin
        w_ctrl = '0;
        if (iRSTn) w_ctrl = ctrl_decode(r_state, w_last, r_md);
    end

    assign oEscrevePC     = w_ctrl.pc_wr;
    assign oEscrevePCCond = w_ctrl.pc_cond;
    assign oIouD          = w_ctrl.iord;
    assign oLeMem         = w_ctrl.mem_rd;
    assign oEscreveMem    = w_ctrl.mem_wr;
    assign oEscreveIR     = w_ctrl.ir_wr;
    assign oEscreveReg    = w_ctrl.reg_wr;
    assign oMemparaReg    = w_ctrl.wb_sel;
    assign oOrigAULA      = w_ctrl.alu_a;
    assign oOrigBULA      = w_ctrl.alu_b;
    assign oOpALU         = w_ctrl.alu_op;
    assign oOrigPC        = w_ctrl.pc_sel;
    assign oIllegal       = r_illegal;
    assign oState         = STATE_W'(r_state);

endmodule

// File: tb/tb_riscv_mc_control.sv
// Scoreboard bench: two instances (MEM_WAIT=0 and 2) run the same directed
// instructions; expected per-cycle control snapshots are queued and compared.
module tb_riscv_mc_control;

    typedef struct packed {
        logic [3:0] st;
        logic       pc, pcc, iord, rd, wr, ir, rg;
        logic [1:0] m2r, a, b, op, opc;
        logic       ill;
    } snap_t;

`ifdef MULDIV_EN
    localparam bit MD = 1'b1;
`else
    localparam bit MD = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rstn = 1'b0;
    logic [6:0] opcode = 7'd0;
    logic [6:0] funct7 = 7'd0;
    logic       done0 = 1'b0, done2 = 1'b0;
    int         mdc0 = 0, mdc2 = 0;

    logic [1:0]      pc, pcc, iord, rd, wr, ir, rg, ill;
    logic [1:0][1:0] m2r, a, b, op, opc;
    logic [1:0][3:0] st;

    snap_t q0[$];
    snap_t q2[$];
    int n_chk = 0, n_pass = 0;

    always #5 clk = ~clk;

    riscv_mc_control #(.MEM_WAIT(0), .STATE_W(4)) dut0 (
        .iCLK(clk), .iRSTn(rstn), .iOpcode(opcode), .iFunct7(funct7), .iMulDivDone(done0),
        .oEscrevePC(pc[0]), .oEscrevePCCond(pcc[0]), .oIouD(iord[0]), .oLeMem(rd[0]),
        .oEscreveMem(wr[0]), .oEscreveIR(ir[0]), .oEscreveReg(rg[0]), .oMemparaReg(m2r[0]),
        .oOrigAULA(a[0]), .oOrigBULA(b[0]), .oOpALU(op[0]), .oOrigPC(opc[0]),
        .oIllegal(ill[0]), .oState(st[0]));

    riscv_mc_control #(.MEM_WAIT(2), .STATE_W(4)) dut2 (
        .iCLK(clk), .iRSTn(rstn), .iOpcode(opcode), .iFunct7(funct7), .iMulDivDone(done2),
        .oEscrevePC(pc[1]), .oEscrevePCCond(pcc[1]), .oIouD(iord[1]), .oLeMem(rd[1]),
        .oEscreveMem(wr[1]), .oEscreveIR(ir[1]), .oEscreveReg(rg[1]), .oMemparaReg(m2r[1]),
        .oOrigAULA(a[1]), .oOrigBULA(b[1]), .oOpALU(op[1]), .oOrigPC(opc[1]),
        .oIllegal(ill[1]), .oState(st[1]));

    function automatic snap_t act(int i);
        snap_t s;
        s = '0;
        s.st = st[i]; s.pc = pc[i]; s.pcc = pcc[i]; s.iord = iord[i]; s.rd = rd[i];
        s.wr = wr[i]; s.ir = ir[i]; s.rg = rg[i]; s.m2r = m2r[i]; s.a = a[i];
        s.b = b[i]; s.op = op[i]; s.opc = opc[i]; s.ill = ill[i];
        return s;
    endfunction

    // Hand-written control table, one row per state.
    function automatic snap_t exp_of(int s_i, bit last, bit md);
        snap_t s;
        s = '0;
        s.st = 4'(s_i);
        case (s_i)
            0:  begin s.rd = 1; s.b = 2'b01; s.ir = last; s.pc = last; end
            1:  begin s.a = 2'b10; s.b = 2'b10; end
            2:  begin s.a = 2'b01; s.b = 2'b00; s.op = 2'b10; end
            3:  begin s.a = 2'b01; s.b = 2'b10; s.op = 2'b11; end
            4:  begin s.rg = 1; s.m2r = md ? 2'b11 : 2'b00; end
            5:  begin s.a = 2'b01; s.b = 2'b10; end
            6:  begin s.iord = 1; s.rd = 1; end
            7:  begin s.rg = 1; s.m2r = 2'b01; end
            8:  begin s.iord = 1; s.wr = 1; end
            9:  begin s.a = 2'b01; s.op = 2'b01; s.pcc = 1; s.opc = 2'b01; end
            10: begin s.rg = 1; s.m2r = 2'b10; s.pc = 1; s.opc = 2'b01; end
            11: begin s.a = 2'b01; s.b = 2'b10; s.rg = 1; s.m2r = 2'b10; s.pc = 1; s.opc = 2'b10; end
            12: begin s.a = 2'b11; s.b = 2'b10; end
            13: begin s.a = 2'b10; s.b = 2'b10; end
            14: s.ill = 1;
            15: s.a = 2'b01;
            default: s = '0;
        endcase
        return s;
    endfunction

    task automatic push(int d, snap_t s);
        if (d == 0) q0.push_back(s); else q2.push_back(s);
    endtask

    task automatic push_mem(int d, int m, int s_i);
        for (int k = 0; k <= m; k++) push(d, exp_of(s_i, k == m, 1'b0));
    endtask

    task automatic push_instr(int d, int m, logic [6:0] oc, logic [6:0] f7);
        push_mem(d, m, 0);
        push(d, exp_of(1, 1'b0, 1'b0));
        case (oc)
            7'b0110011: begin
                if (MD && f7 == 7'b0000001) begin
                    for (int k = 0; k < 5; k++) push(d, exp_of(15, 1'b0, 1'b0));
                    push(d, exp_of(4, 1'b0, 1'b1));
                end else begin
                    push(d, exp_of(2, 1'b0, 1'b0)); push(d, exp_of(4, 1'b0, 1'b0));
                end
            end
            7'b0010011: begin push(d, exp_of(3, 1'b0, 1'b0)); push(d, exp_of(4, 1'b0, 1'b0)); end
            7'b0000011: begin push(d, exp_of(5, 1'b0, 1'b0)); push_mem(d, m, 6); push(d, exp_of(7, 1'b0, 1'b0)); end
            7'b0100011: begin push(d, exp_of(5, 1'b0, 1'b0)); push_mem(d, m, 8); end
            7'b1100011: push(d, exp_of(9, 1'b0, 1'b0));
            7'b1101111: push(d, exp_of(10, 1'b0, 1'b0));
            7'b1100111: push(d, exp_of(11, 1'b0, 1'b0));
            7'b0110111: begin push(d, exp_of(12, 1'b0, 1'b0)); push(d, exp_of(4, 1'b0, 1'b0)); end
            7'b0010111: begin push(d, exp_of(13, 1'b0, 1'b0)); push(d, exp_of(4, 1'b0, 1'b0)); end
            default: begin
                for (int k = 0; k < 20; k++) push(d, exp_of(14, 1'b0, 1'b0));
                return;
            end
        endcase
        push(d, exp_of(0, m == 0, 1'b0));
    endtask

    // Reset is asserted mid-cycle, so the zero snapshot checked at the next
    // negedge can only hold if the reset acts asynchronously.
    task automatic run(logic [6:0] oc, logic [6:0] f7);
        @(posedge clk); #1;
        rstn = 1'b0; opcode = oc; funct7 = f7;
        push(0, '0); push(1, '0);
        @(posedge clk); #1;
        rstn = 1'b1;
        push_instr(0, 0, oc, f7);
        push_instr(1, 2, oc, f7);
        for (int i = 0; i < 200 && (q0.size() != 0 || q2.size() != 0); i++) @(posedge clk);
        if (q0.size() != 0 || q2.size() != 0) begin
            n_chk++;
            $display("FAIL drain opcode=%b: left %0d/%0d entries, required 0", oc, q0.size(), q2.size());
            q0.delete(); q2.delete();
        end
    endtask

    always @(negedge clk) begin
        snap_t e, g;
        if (q0.size() != 0) begin
            e = q0.pop_front(); g = act(0); n_chk++;
            if (g === e) n_pass++;
            else $display("FAIL dut0 cycle: got st=%0d ctrl=%h, required st=%0d ctrl=%h", g.st, g, e.st, e);
        end
        if (q2.size() != 0) begin
            e = q2.pop_front(); g = act(1); n_chk++;
            if (g === e) n_pass++;
            else $display("FAIL dut2 cycle: got st=%0d ctrl=%h, required st=%0d ctrl=%h", g.st, g, e.st, e);
        end
    end

    // M-unit model: done rises in the fifth cycle spent in MULDIV.
    always @(negedge clk) begin
        mdc0 = (st[0] == 4'd15) ? mdc0 + 1 : 0;
        mdc2 = (st[1] == 4'd15) ? mdc2 + 1 : 0;
        done0 = (mdc0 == 5);
        done2 = (mdc2 == 5);
    end

    initial begin
        run(7'b0110011, 7'b0000000);
        run(7'b0000011, 7'b0000000);
        run(7'b0100011, 7'b0000000);
        run(7'b1100111, 7'b0000000);
        run(7'b1111111, 7'b0000000);
        run(7'b0010011, 7'b0000000);
        run(7'b1100011, 7'b0000000);
        run(7'b1101111, 7'b0000000);
        run(7'b0110111, 7'b0000000);
        run(7'b0010111, 7'b0000000);
        run(7'b0000000, 7'b0000000);
        run(7'b0110011, 7'b0000001);
        run(7'b0000011, 7'b0000000);
        repeat (2) @(posedge clk);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/riscv_mc_control.md
Name: riscv_mc_control

Overview:
- Multicycle control unit for the RV32I multicycle core; successor to the single-cycle opcode decoder.
- Moore FSM sequences fetch/decode/execute/memory/writeback over several cycles and drives datapath mux selects and write enables.
- A parametrised memory-wait counter stretches memory states for slow memories.
- Illegal opcodes trap to a halt state.

Parameters:
- MEM_WAIT, 0, extra wait cycles per memory access (0..15); each memory state lasts MEM_WAIT+1 cycles.
- STATE_W, 4, state register width.

Ports:
- iCLK  in  1  core clock
- iRSTn  in  1  asynchronous active-low reset
- iOpcode  in  7  IR[6:0]
- iFunct7  in  7  IR[31:25]; used only with MULDIV_EN
- iMulDivDone  in  1  M-unit result valid; used only with MULDIV_EN
- oEscrevePC  out  1  unconditional PC write
- oEscrevePCCond  out  1  PC write if branch taken
- oIouD  out  1  memory address select: 0=PC, 1=ALUOut
- oLeMem  out  1  memory read
- oEscreveMem  out  1  memory write
- oEscreveIR  out  1  IR and PCold load
- oEscreveReg  out  1  register-file write
- oMemparaReg  out  2  writeback select: 00 ALUOut, 01 MDR, 10 PC+4, 11 M-unit
- oOrigAULA  out  2  ALU A: 00 PC, 01 rs1, 10 PCold, 11 zero
- oOrigBULA  out  2  ALU B: 00 rs2, 01 const 4, 10 imm
- oOpALU  out  2  00 add, 01 branch compare, 10 R-funct, 11 I-funct
- oOrigPC  out  2  00 ALU result, 01 ALUOut, 10 ALU result & ~1
- oIllegal  out  1  sticky illegal-opcode flag
- oState  out  STATE_W  current state, for debug

Behaviour:
- Reset (iRSTn=0, async): state=FETCH, wait counter=0, oIllegal=0. All outputs are 0 while reset is held. oState=0.
- Outputs are a pure function of the registered state and the counter; no combinational path from iOpcode to outputs.
- Wait counter: counts 0..MEM_WAIT in FETCH, MEM_RD and MEM_WR, then clears on state exit. "last" means cnt==MEM_WAIT.
- FETCH (0):
  - Drives IouD=0, LeMem=1, A=00, B=01, OpALU=00.
  - EscreveIR and EscrevePC=1 only on the last cycle; OrigPC=00.
  - Goes to DECODE on last.
- DECODE (1): A=10, B=10, add (branch/JAL target into ALUOut). Next state by iOpcode:
  - OP → EXEC_R
  - OP_IMM → EXEC_I
  - LOAD/STORE → MEM_ADDR
  - BRANCH → BRANCH
  - JAL → JAL
  - JALR → JALR
  - LUI → LUI
  - AUIPC → AUIPC
  - anything else → TRAP
- EXEC_R (2): A=01, B=00, OpALU=10 → ALU_WB.
- EXEC_I (3): A=01, B=10, OpALU=11 → ALU_WB.
- ALU_WB (4): EscreveReg=1, MemparaReg=00 → FETCH.
- MEM_ADDR (5): A=01, B=10, add → MEM_RD for LOAD, MEM_WR for STORE.
- MEM_RD (6): IouD=1, LeMem=1 for MEM_WAIT+1 cycles → MEM_WB.
- MEM_WB (7): EscreveReg=1, MemparaReg=01 → FETCH.
- MEM_WR (8): IouD=1, EscreveMem=1 for MEM_WAIT+1 cycles → FETCH.
- BRANCH (9): A=01, B=00, OpALU=01, EscrevePCCond=1, OrigPC=01 → FETCH.
- JAL (10): EscreveReg=1, MemparaReg=10, EscrevePC=1, OrigPC=01 → FETCH.
- JALR (11): A=01, B=10, add, EscreveReg=1, MemparaReg=10, EscrevePC=1, OrigPC=10 → FETCH.
- LUI (12): A=11, B=10, add → ALU_WB.
- AUIPC (13): A=10, B=10, add → ALU_WB.
- TRAP (14): all write enables 0, oIllegal=1. Held until reset.
- Instruction cycle counts (M = MEM_WAIT):
  - R/I/LUI/AUIPC: 4+M
  - LOAD: 5+2M
  - STORE: 4+2M
  - BRANCH/JAL/JALR: 3+M
- Reset mid-instruction aborts immediately; no partial write persists after reset.

Optional Feature:
- Macro MULDIV_EN.
- With the macro: DECODE with OP and iFunct7=7'b0000001 goes to MULDIV (15). MULDIV drives A=01, B=00, all write enables 0 and waits on iMulDivDone. On iMulDivDone=1 it goes to ALU_WB, which then drives MemparaReg=11.
- Without the macro: iFunct7 and iMulDivDone are ignored, state 15 is unreachable, and such instructions go to EXEC_R.

Decomposition:
- State encodings ST_FETCH..ST_MULDIV, the select-code constants and opcode constants go in the shared parameter header alongside the existing OPC_* definitions.
- One sub-module: mc_wait_counter (MEM_WAIT parameter, enable/clear inputs, last output).

Test Plan:
- MEM_WAIT=0, reset release, opcode 0110011: oState sequence 0,1,2,4,0. oEscreveReg=1 only in state 4; oEscreveIR/oEscrevePC=1 for 1 cycle in state 0.
- MEM_WAIT=2, opcode 0000011: FETCH lasts 3 cycles, MEM_RD 3 cycles with oIouD=1 and oLeMem=1, MEM_WB has oMemparaReg=01. Total 9 cycles.
- Opcode 0100011 with MEM_WAIT=1: oEscreveMem=1 for exactly 2 cycles; oEscreveReg is never asserted.
- Opcode 1100111: JALR asserts oEscrevePC=1, oOrigPC=10, oMemparaReg=10 in the same cycle. Total 3 cycles, then back in FETCH.
- Opcode 1111111: state goes to 14 and oIllegal=1 for 20 cycles. Asserting iRSTn=0 mid-hold gives oState=0 and oIllegal=0 asynchronously.
- MULDIV_EN, opcode 0110011 with funct7 0000001, iMulDivDone raised after 5 cycles: stays in 15 for 5 cycles, then ALU_WB with oMemparaReg=11.
